hash_check: RTL and testbench
=============================

# hash_check

Streaming hash checker: the receiving end of a hashed transfer.
- Accepts a frame of IN_WIDTH-bit beats over a valid/ready handshake and folds each beat into a running OUT_WIDTH-bit digest.
- On the last beat, compares the masked digest against the expected hash delivered with that beat, then reports match, beat count and an overflow flag.
- Sits downstream of any block that tags a data stream with the byte-fold hash, and keeps saturating pass/fail statistics for debug readout.

## Interface
Parameters:
- IN_WIDTH, 40: beat width. Fixed at 40.
- OUT_WIDTH, 8: digest width. Fixed at 8.
- MAX_BEATS, 16: longest legal frame, in beats. Range 1..65534.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid_RnnH  in  1  beat valid
- in_ready_RnnH  out  1  block can accept a beat
- in_data_RnnH  in  IN_WIDTH  beat payload
- in_last_RnnH  in  1  beat is the final beat of its frame
- exp_hash_RnnH  in  OUT_WIDTH  expected hash; sampled only on an accepted last beat
- mask_RnnH  in  OUT_WIDTH  compare mask; sampled only on an accepted last beat
- res_valid_RnnH  out  1  result available
- res_ready_RnnH  in  1  consumer accepts the result
- res_match_RnnH  out  1  masked digest equals masked expected hash, and no overflow
- res_hash_RnnH  out  OUT_WIDTH  final unmasked digest
- res_beats_RnnU  out  16  beats in the frame; saturates at 0xFFFF
- res_ovf_RnnH  out  1  frame exceeded MAX_BEATS
- pass_cnt_RnnU  out  16  frames that matched; saturating
- fail_cnt_RnnU  out  16  frames that did not match; saturating

## Operation
Beat acceptance:
- A beat is accepted when in_valid_RnnH && in_ready_RnnH.

Per-beat digest:
- d = in_data[7:0] ^ in_data[39:32].
- This equals the full 40→8 XOR tree (bytes 0⊕1, 1⊕2, 2⊕3, 3⊕4, then pairwise, then final) and must match it bit-exactly.

Accumulator:
- acc is OUT_WIDTH bits and starts at 0 for each frame.
- On every accepted beat: acc_next = {acc[6:0], acc[7]} ^ d, i.e. rotate left by 1, then XOR. This makes the digest order-sensitive.

Beat counter:
- beats increments on every accepted beat and saturates at 0xFFFF.
- ovf sets when an accepted beat makes beats > MAX_BEATS; it stays set until the frame ends.

State machine:
- ACCUM:
  - in_ready_RnnH = 1.
  - A non-last beat updates acc and beats and stays in ACCUM.
  - A last beat computes the final acc, beats and ovf, latches the result registers, and moves to RESULT.
  - Result registers: res_hash = acc_next, res_beats, res_ovf, and res_match = (((acc_next ^ exp_hash) & mask) == 0) && !ovf_next.
  - The same last beat resets acc, beats and ovf to 0 and increments pass_cnt or fail_cnt according to res_match.
- RESULT:
  - in_ready_RnnH = 0 and res_valid_RnnH = 1.
  - Result outputs hold stable.
  - When res_ready_RnnH = 1, move to ACCUM.

Edge cases:
- A one-beat frame (last on its first beat) is legal.
- A frame of exactly MAX_BEATS beats has ovf = 0.
- Counters saturate at 0xFFFF and never wrap.
- Reset asserted mid-frame or in RESULT discards the partial frame and any pending result.

## Timing
Reset values:
- State ACCUM, acc = 0, beats = 0, ovf = 0.
- in_ready_RnnH = 1, res_valid_RnnH = 0, res_match_RnnH = 0, res_hash_RnnH = 0, res_beats_RnnU = 0, res_ovf_RnnH = 0.
- pass_cnt_RnnU = 0, fail_cnt_RnnU = 0.
- Reset takes priority over every other event in the same cycle.

Latency and throughput:
- Accepting the last beat in cycle N gives res_valid_RnnH = 1 in cycle N+1.
- pass_cnt_RnnU or fail_cnt_RnnU shows the increment in cycle N+1.
- There is no bypass: a result accepted in cycle M gives in_ready_RnnH = 1 in cycle M+1.
- Minimum spacing is 2 cycles per one-beat frame.
- in_ready_RnnH and res_valid_RnnH are decoded from registered state only, with no combinational path from in_valid_RnnH or res_ready_RnnH.

Handshake rules:
- res_valid_RnnH stays high, with all res_* outputs stable, until res_ready_RnnH is sampled high.
- in_data_RnnH, in_last_RnnH, exp_hash_RnnH and mask_RnnH are don't-care when no beat is accepted.

## Test plan
- **One-beat frame, match:** in_data = 0x11_0000_0022, last = 1, exp = 0x33, mask = 0xFF → next cycle res_valid = 1, res_hash = 0x33, res_match = 1, res_beats = 1, pass_cnt = 1.
- **Two-beat frame, order sensitivity:** beats 0x00_0000_0001 then 0x01_0000_0000 (last), exp = 0x03, mask = 0xFF → res_hash = 0x03, match = 1. Repeat with exp = 0x07 → match = 0, fail_cnt = 1. Repeat with exp = 0x07, mask = 0xFB → match = 1.
- **Overflow at MAX_BEATS = 16:** 16 zero beats with exp = 0x00 → ovf = 0, match = 1, beats = 16. 17 zero beats with exp = 0x00 → ovf = 1, match = 0, beats = 17.
- **Backpressure:** hold res_ready = 0 for 5 cycles after a result → res_valid and all res_* stable, in_ready = 0 throughout, no beats accepted. res_ready = 1 → in_ready = 1 on the following cycle.
- **Reset mid-frame:** accept 3 beats, assert rst for 1 cycle, then send the one-beat match frame from the first scenario → res_beats = 1, res_hash = 0x33, counters reflect only post-reset frames.
- **Random regression:** random frames of 1–20 beats with random in_valid/res_ready gaps, checked against a scoreboard model. Force fail_cnt near 0xFFFF and confirm it saturates.

Source files
------------

// File: rtl/hash_check.sv
// Streaming hash checker: folds 40-bit beats into an order-sensitive 8-bit digest
// and compares it against an expected hash when the last beat of a frame arrives.
module hash_check #(
  parameter int IN_WIDTH  = 40,
  parameter int OUT_WIDTH = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_RnnH,
  output logic                 in_ready_RnnH,
  input  logic [IN_WIDTH-1:0]  in_data_RnnH,
  input  logic                 in_last_RnnH,
  input  logic [OUT_WIDTH-1:0] exp_hash_RnnH,
  input  logic [OUT_WIDTH-1:0] mask_RnnH,
  output logic                 res_valid_RnnH,
  input  logic                 res_ready_RnnH,
  output logic                 res_match_RnnH,
  output logic [OUT_WIDTH-1:0] res_hash_RnnH,
  output logic [15:0]          res_beats_RnnU,
  output logic                 res_ovf_RnnH,
  output logic [15:0]          pass_cnt_RnnU,
  output logic [15:0]          fail_cnt_RnnU
);

  localparam int             N_BYTES = IN_WIDTH / 8;
  localparam logic [15:0]    MAX_B   = 16'(MAX_BEATS);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [OUT_WIDTH-1:0]  r_acc;
  logic [15:0]           r_beats;
  logic                  r_ovf;
  logic                  r_res_match;
  logic [OUT_WIDTH-1:0]  r_res_hash;
  logic [15:0]           r_res_beats;
  logic                  r_res_ovf;
  logic [15:0]           r_pass_cnt;
  logic [15:0]           r_fail_cnt;

  logic                  w_accept;
  logic                  w_last_accept;
  logic [7:0]            w_pair [N_BYTES-1];
  logic [7:0]            w_d;
  logic [OUT_WIDTH-1:0]  w_acc_next;
  logic [15:0]           w_beats_next;
  logic                  w_ovf_next;
  logic                  w_match;

  // Full XOR tree over adjacent byte pairs; it reduces to byte0 ^ byte4.
  generate
    for (genvar gi = 0; gi < N_BYTES - 1; gi++) begin : g_pair
      assign w_pair[gi] = in_data_RnnH[8*gi +: 8] ^ in_data_RnnH[8*(gi+1) +: 8];
    end
  endgenerate

  assign w_d = (w_pair[0] ^ w_pair[1]) ^ (w_pair[2] ^ w_pair[3]);

  assign w_accept      = in_valid_RnnH & in_ready_RnnH;
  assign w_last_accept = w_accept & in_last_RnnH;
  assign w_acc_next    = {r_acc[OUT_WIDTH-2:0], r_acc[OUT_WIDTH-1]} ^ w_d;
  assign w_beats_next  = (&r_beats) ? r_beats : r_beats + 16'd1;
  assign w_ovf_next    = r_ovf | (w_beats_next > MAX_B);
  assign w_match       = (((w_acc_next ^ exp_hash_RnnH) & mask_RnnH) == '0) && !w_ovf_next;

  always_comb begin
    w_state_next   = r_state;
    in_ready_RnnH  = 1'b0;
    res_valid_RnnH = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        in_ready_RnnH = 1'b1;
        if (w_last_accept) w_state_next = ST_RESULT;
      end
      ST_RESULT: begin
        res_valid_RnnH = 1'b1;
        if (res_ready_RnnH) w_state_next = ST_ACCUM;
      end
      default: w_state_next = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_ACCUM;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_res_match <= 1'b0;
      r_res_hash  <= '0;
      r_res_beats <= '0;
      r_res_ovf   <= 1'b0;
      r_pass_cnt  <= '0;
      r_fail_cnt  <= '0;
    end else if (w_last_accept) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_ovf       <= 1'b0;
      r_res_match <= w_match;
      r_res_hash  <= w_acc_next;
      r_res_beats <= w_beats_next;
      r_res_ovf   <= w_ovf_next;
      if (w_match) r_pass_cnt <= (&r_pass_cnt) ? r_pass_cnt : r_pass_cnt + 16'd1;
      else         r_fail_cnt <= (&r_fail_cnt) ? r_fail_cnt : r_fail_cnt + 16'd1;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_beats <= w_beats_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign res_match_RnnH = r_res_match;
  assign res_hash_RnnH  = r_res_hash;
  assign res_beats_RnnU = r_res_beats;
  assign res_ovf_RnnH   = r_res_ovf;
  assign pass_cnt_RnnU  = r_pass_cnt;
  assign fail_cnt_RnnU  = r_fail_cnt;

endmodule

// File: tb/tb_hash_check.sv
// Randomized self-checking bench for hash_check with a frame-level reference model.
module tb_hash_check;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_RnnH;
  logic        in_ready_RnnH;
  logic [39:0] in_data_RnnH;
  logic        in_last_RnnH;
  logic [7:0]  exp_hash_RnnH;
  logic [7:0]  mask_RnnH;
  logic        res_valid_RnnH;
  logic        res_ready_RnnH;
  logic        res_match_RnnH;
  logic [7:0]  res_hash_RnnH;
  logic [15:0] res_beats_RnnU;
  logic        res_ovf_RnnH;
  logic [15:0] pass_cnt_RnnU;
  logic [15:0] fail_cnt_RnnU;

  always #5 clk = ~clk;

  hash_check #(.IN_WIDTH(40), .OUT_WIDTH(8), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid_RnnH(in_valid_RnnH), .in_ready_RnnH(in_ready_RnnH),
    .in_data_RnnH(in_data_RnnH), .in_last_RnnH(in_last_RnnH),
    .exp_hash_RnnH(exp_hash_RnnH), .mask_RnnH(mask_RnnH),
    .res_valid_RnnH(res_valid_RnnH), .res_ready_RnnH(res_ready_RnnH),
    .res_match_RnnH(res_match_RnnH), .res_hash_RnnH(res_hash_RnnH),
    .res_beats_RnnU(res_beats_RnnU), .res_ovf_RnnH(res_ovf_RnnH),
    .pass_cnt_RnnU(pass_cnt_RnnU), .fail_cnt_RnnU(fail_cnt_RnnU)
  );

  int checks = 0;
  int errors = 0;

  // Frame under construction and model state
  logic [39:0] fb [0:31];
  int          fn;
  int          m_pass;
  int          m_fail;
  int          e_hash;
  int          e_match;
  int          e_ovf;

  // Digest from the arithmetic definition: rotate-left-by-one then XOR the folded beat.
  function automatic int model_hash(input int n);
    int a;
    int d;
    a = 0;
    for (int i = 0; i < n; i++) begin
      d = int'(fb[i][7:0]) ^ int'(fb[i][15:8]) ^ int'(fb[i][15:8]) ^ int'(fb[i][39:32]);
      a = (((a * 2) % 256) + (a / 128)) ^ d;
    end
    return a;
  endfunction

  // Compute expectations for the current frame and advance the model counters.
  task automatic model_frame(input logic [7:0] exp, input logic [7:0] mask);
    e_hash  = model_hash(fn);
    e_ovf   = (fn > 16) ? 1 : 0;
    e_match = (((e_hash ^ int'(exp)) & int'(mask)) == 0 && e_ovf == 0) ? 1 : 0;
    if (e_match == 1) m_pass = (m_pass < 65535) ? m_pass + 1 : 65535;
    else              m_fail = (m_fail < 65535) ? m_fail + 1 : 65535;
  endtask

  task automatic drive_frame(input int gap_max, input logic [7:0] exp, input logic [7:0] mask);
    for (int i = 0; i < fn; i++) begin
      in_valid_RnnH = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin
        @(posedge clk); #1;
      end
      in_valid_RnnH = 1'b1;
      in_data_RnnH  = fb[i];
      in_last_RnnH  = (i == fn - 1);
      exp_hash_RnnH = (i == fn - 1) ? exp : 8'($urandom);
      mask_RnnH     = (i == fn - 1) ? mask : 8'($urandom);
      if (in_ready_RnnH !== 1'b1) begin
        $display("FAIL beat_ready beat=%0d got=%b want=1", i, in_ready_RnnH);
        errors++;
      end
      @(posedge clk); #1;
    end
    in_valid_RnnH = 1'b0;
    in_last_RnnH  = 1'b0;
  endtask

  task automatic take_result(input int hold);
    int waited;
    res_ready_RnnH = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    res_ready_RnnH = 1'b1;
    waited = 0;
    while (res_valid_RnnH !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    res_ready_RnnH = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    m_pass = 0;
    m_fail = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 8;
    if (in_ready_RnnH !== 1'b1)   begin $display("FAIL rst_in_ready got=%b want=1", in_ready_RnnH); errors++; end
    if (res_valid_RnnH !== 1'b0)  begin $display("FAIL rst_res_valid got=%b want=0", res_valid_RnnH); errors++; end
    if (res_match_RnnH !== 1'b0)  begin $display("FAIL rst_res_match got=%b want=0", res_match_RnnH); errors++; end
    if (res_hash_RnnH !== 8'h00)  begin $display("FAIL rst_res_hash got=%h want=00", res_hash_RnnH); errors++; end
    if (res_beats_RnnU !== 16'h0) begin $display("FAIL rst_res_beats got=%0d want=0", res_beats_RnnU); errors++; end
    if (res_ovf_RnnH !== 1'b0)    begin $display("FAIL rst_res_ovf got=%b want=0", res_ovf_RnnH); errors++; end
    if (pass_cnt_RnnU !== 16'h0)  begin $display("FAIL rst_pass_cnt got=%0d want=0", pass_cnt_RnnU); errors++; end
    if (fail_cnt_RnnU !== 16'h0)  begin $display("FAIL rst_fail_cnt got=%0d want=0", fail_cnt_RnnU); errors++; end
    $display("reset: in_ready=%b res_valid=%b", in_ready_RnnH, res_valid_RnnH);
  endtask

  task automatic test_one_beat();
    fb[0] = 40'h11_0000_0022;
    fn = 1;
    drive_frame(0, 8'h33, 8'hFF);
    model_frame(8'h33, 8'hFF);
    checks += 5;
    if (res_valid_RnnH !== 1'b1)       begin $display("FAIL one_valid got=%b want=1", res_valid_RnnH); errors++; end
    if (res_hash_RnnH !== 8'h33)       begin $display("FAIL one_hash got=%h want=33", res_hash_RnnH); errors++; end
    if (res_match_RnnH !== 1'b1)       begin $display("FAIL one_match got=%b want=1", res_match_RnnH); errors++; end
    if (res_beats_RnnU !== 16'd1)      begin $display("FAIL one_beats got=%0d want=1", res_beats_RnnU); errors++; end
    if (pass_cnt_RnnU !== 16'(m_pass)) begin $display("FAIL one_pass got=%0d want=%0d", pass_cnt_RnnU, m_pass); errors++; end
    $display("one_beat: hash=%h match=%b beats=%0d pass=%0d", res_hash_RnnH, res_match_RnnH, res_beats_RnnU, pass_cnt_RnnU);
    take_result(0);
  endtask

  task automatic test_order();
    logic [7:0] exps  [3];
    logic [7:0] masks [3];
    int         wantm [3];
    exps  = '{8'h03, 8'h07, 8'h07};
    masks = '{8'hFF, 8'hFF, 8'hFB};
    wantm = '{1, 0, 1};
    for (int k = 0; k < 3; k++) begin
      fb[0] = 40'h00_0000_0001;
      fb[1] = 40'h01_0000_0000;
      fn = 2;
      drive_frame(1, exps[k], masks[k]);
      model_frame(exps[k], masks[k]);
      checks += 4;
      if (res_hash_RnnH !== 8'h03)          begin $display("FAIL order_hash k=%0d got=%h want=03", k, res_hash_RnnH); errors++; end
      if (res_match_RnnH !== 1'(wantm[k]))  begin $display("FAIL order_match k=%0d got=%b want=%0d", k, res_match_RnnH, wantm[k]); errors++; end
      if (pass_cnt_RnnU !== 16'(m_pass))    begin $display("FAIL order_pass k=%0d got=%0d want=%0d", k, pass_cnt_RnnU, m_pass); errors++; end
      if (fail_cnt_RnnU !== 16'(m_fail))    begin $display("FAIL order_fail k=%0d got=%0d want=%0d", k, fail_cnt_RnnU, m_fail); errors++; end
      $display("order k=%0d: hash=%h match=%b pass=%0d fail=%0d", k, res_hash_RnnH, res_match_RnnH, pass_cnt_RnnU, fail_cnt_RnnU);
      take_result(k);
    end
  endtask

  task automatic test_overflow();
    for (int len = 16; len <= 17; len++) begin
      for (int i = 0; i < len; i++) fb[i] = '0;
      fn = len;
      drive_frame(0, 8'h00, 8'hFF);
      model_frame(8'h00, 8'hFF);
      checks += 4;
      if (res_ovf_RnnH !== 1'(len > 16))   begin $display("FAIL ovf_flag len=%0d got=%b", len, res_ovf_RnnH); errors++; end
      if (res_match_RnnH !== 1'(len == 16)) begin $display("FAIL ovf_match len=%0d got=%b", len, res_match_RnnH); errors++; end
      if (res_beats_RnnU !== 16'(len))      begin $display("FAIL ovf_beats got=%0d want=%0d", res_beats_RnnU, len); errors++; end
      if (fail_cnt_RnnU !== 16'(m_fail))    begin $display("FAIL ovf_fail got=%0d want=%0d", fail_cnt_RnnU, m_fail); errors++; end
      $display("overflow len=%0d: ovf=%b match=%b beats=%0d", len, res_ovf_RnnH, res_match_RnnH, res_beats_RnnU);
      take_result(0);
    end
  endtask

  task automatic test_backpressure();
    fb[0] = 40'hA5_1234_5678;
    fb[1] = 40'h3C_0F0F_0F0F;
    fb[2] = 40'h00_FFFF_FF81;
    fn = 3;
    drive_frame(0, 8'h00, 8'h00);
    model_frame(8'h00, 8'h00);
    res_ready_RnnH = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid_RnnH = 1'b1;
      in_last_RnnH  = 1'b1;
      in_data_RnnH  = {$urandom, 8'($urandom)};
      checks += 5;
      if (res_valid_RnnH !== 1'b1)        begin $display("FAIL bp_valid c=%0d got=%b want=1", c, res_valid_RnnH); errors++; end
      if (in_ready_RnnH !== 1'b0)         begin $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready_RnnH); errors++; end
      if (res_hash_RnnH !== 8'(e_hash))   begin $display("FAIL bp_hash c=%0d got=%h want=%h", c, res_hash_RnnH, 8'(e_hash)); errors++; end
      if (res_beats_RnnU !== 16'd3)       begin $display("FAIL bp_beats c=%0d got=%0d want=3", c, res_beats_RnnU); errors++; end
      if (pass_cnt_RnnU !== 16'(m_pass))  begin $display("FAIL bp_pass c=%0d got=%0d want=%0d", c, pass_cnt_RnnU, m_pass); errors++; end
      @(posedge clk); #1;
    end
    in_valid_RnnH  = 1'b0;
    in_last_RnnH   = 1'b0;
    res_ready_RnnH = 1'b1;
    @(posedge clk); #1;
    res_ready_RnnH = 1'b0;
    checks += 2;
    if (in_ready_RnnH !== 1'b1)  begin $display("FAIL bp_release_ready got=%b want=1", in_ready_RnnH); errors++; end
    if (res_valid_RnnH !== 1'b0) begin $display("FAIL bp_release_valid got=%b want=0", res_valid_RnnH); errors++; end
    $display("backpressure: hash=%h in_ready=%b", res_hash_RnnH, in_ready_RnnH);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) fb[i] = {$urandom, 8'($urandom)};
    fn = 3;
    for (int i = 0; i < 3; i++) begin
      in_valid_RnnH = 1'b1;
      in_data_RnnH  = fb[i];
      in_last_RnnH  = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_RnnH = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_pass = 0;
    m_fail = 0;
    fb[0] = 40'h11_0000_0022;
    fn = 1;
    drive_frame(0, 8'h33, 8'hFF);
    model_frame(8'h33, 8'hFF);
    checks += 4;
    if (res_beats_RnnU !== 16'd1)      begin $display("FAIL rmid_beats got=%0d want=1", res_beats_RnnU); errors++; end
    if (res_hash_RnnH !== 8'h33)       begin $display("FAIL rmid_hash got=%h want=33", res_hash_RnnH); errors++; end
    if (pass_cnt_RnnU !== 16'(m_pass)) begin $display("FAIL rmid_pass got=%0d want=%0d", pass_cnt_RnnU, m_pass); errors++; end
    if (fail_cnt_RnnU !== 16'(m_fail)) begin $display("FAIL rmid_fail got=%0d want=%0d", fail_cnt_RnnU, m_fail); errors++; end
    $display("reset_mid: beats=%0d hash=%h pass=%0d", res_beats_RnnU, res_hash_RnnH, pass_cnt_RnnU);
    take_result(1);
  endtask

  task automatic test_random();
    logic [7:0] exp;
    logic [7:0] mask;
    for (int f = 0; f < 40; f++) begin
      fn = $urandom_range(1, 20);
      for (int i = 0; i < fn; i++) fb[i] = {$urandom, 8'($urandom)};
      mask = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom);
      exp  = ($urandom_range(0, 1) == 1) ? 8'(model_hash(fn)) : 8'($urandom);
      drive_frame(2, exp, mask);
      model_frame(exp, mask);
      checks += 6;
      if (res_valid_RnnH !== 1'b1)          begin $display("FAIL rnd_valid f=%0d got=%b want=1", f, res_valid_RnnH); errors++; end
      if (res_hash_RnnH !== 8'(e_hash))     begin $display("FAIL rnd_hash f=%0d got=%h want=%h", f, res_hash_RnnH, 8'(e_hash)); errors++; end
      if (res_beats_RnnU !== 16'(fn))       begin $display("FAIL rnd_beats f=%0d got=%0d want=%0d", f, res_beats_RnnU, fn); errors++; end
      if (res_ovf_RnnH !== 1'(e_ovf))       begin $display("FAIL rnd_ovf f=%0d got=%b want=%0d", f, res_ovf_RnnH, e_ovf); errors++; end
      if (res_match_RnnH !== 1'(e_match))   begin $display("FAIL rnd_match f=%0d got=%b want=%0d", f, res_match_RnnH, e_match); errors++; end
      if (pass_cnt_RnnU !== 16'(m_pass) || fail_cnt_RnnU !== 16'(m_fail)) begin
        $display("FAIL rnd_counts f=%0d got=%0d/%0d want=%0d/%0d", f, pass_cnt_RnnU, fail_cnt_RnnU, m_pass, m_fail);
        errors++;
      end
      $display("random f=%0d: len=%0d hash=%h match=%b ovf=%b", f, fn, res_hash_RnnH, res_match_RnnH, res_ovf_RnnH);
      take_result($urandom_range(0, 3));
    end
  endtask

  task automatic test_saturation();
    dut.r_fail_cnt = 16'hFFFD;
    m_fail = 65533;
    for (int k = 0; k < 4; k++) begin
      fb[0] = 40'h0;
      fn = 1;
      drive_frame(0, 8'hFF, 8'hFF);
      model_frame(8'hFF, 8'hFF);
      checks += 2;
      if (fail_cnt_RnnU !== 16'(m_fail)) begin $display("FAIL sat_fail k=%0d got=%h want=%h", k, fail_cnt_RnnU, 16'(m_fail)); errors++; end
      if (res_match_RnnH !== 1'b0)       begin $display("FAIL sat_match k=%0d got=%b want=0", k, res_match_RnnH); errors++; end
      $display("saturation k=%0d: fail_cnt=%h", k, fail_cnt_RnnU);
      take_result(0);
    end
  endtask

  initial begin
    rst            = 1'b1;
    in_valid_RnnH  = 1'b0;
    in_data_RnnH   = '0;
    in_last_RnnH   = 1'b0;
    exp_hash_RnnH  = '0;
    mask_RnnH      = '0;
    res_ready_RnnH = 1'b0;
    m_pass         = 0;
    m_fail         = 0;
    @(posedge clk); #1;
    test_reset();
    test_one_beat();
    test_order();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
